hamming_seq_ctrl: RTL and testbench
===================================

Name: hamming_seq_ctrl

Overview:
- Sequencer for the SECDED (16,11) decode datapath.
- On an init pulse it walks NUM_WORDS encoded 16-bit words stored as byte pairs in data memory.
- For each word it hands the word to the external decoder through a req/ack handshake, then writes the 16-bit result (flags in [15:14], message in [10:0]) back to memory as a byte pair.
- Sits in top_level between the data memory and the decoder datapath, and raises done when the batch is complete.

Parameters:
- AW, 8, memory address width.
- SRC_BASE, 64, byte address of the first encoded word's low byte.
- DST_BASE, 94, byte address of the first result word's low byte.
- NUM_WORDS, 15, number of words processed per init.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  start pulse, sampled on clk.
- done  output  1  batch complete (level).
- mem_addr  output  AW  data memory byte address.
- mem_wr_en  output  1  memory write strobe.
- mem_wr_data  output  8  write byte.
- mem_rd_data  input  8  read byte; combinational read of mem_addr.
- dec_req  output  1  codeword valid to decoder.
- dec_word  output  16  codeword {hi byte, lo byte}.
- dec_ack  input  1  decoder result valid; same cycle as or later than dec_req.
- dec_result  input  16  decoded word, sampled when dec_ack=1.
- sgl_cnt  output  8  single-error count (see optional feature).
- dbl_cnt  output  8  double-error count (see optional feature).

Behaviour:
- Reset (async, takes effect immediately): state=IDLE; idx=0; done=0; dec_req=0; mem_wr_en=0; mem_addr=0; mem_wr_data=0; dec_word=0; sgl_cnt=dbl_cnt=0. Reset mid-batch abandons the batch; no further writes occur.
- States:
  - IDLE: outputs inactive. If init=1, then idx<=0 and go to RD_LO.
  - RD_LO: mem_addr=SRC_BASE+2*idx. Latch mem_rd_data into lo. Go to RD_HI.
  - RD_HI: mem_addr=SRC_BASE+2*idx+1. Latch mem_rd_data into hi. Go to DEC.
  - DEC: dec_req=1; dec_word={hi,lo}, held stable. When dec_ack=1, latch dec_result into res and go to WR_LO. Otherwise stay in DEC with no limit (no timeout).
  - WR_LO: mem_addr=DST_BASE+2*idx; mem_wr_en=1; mem_wr_data=res[7:0]. Go to WR_HI.
  - WR_HI: mem_addr=DST_BASE+2*idx+1; mem_wr_en=1; mem_wr_data=res[15:8]. If idx==NUM_WORDS-1, go to DONE; else idx<=idx+1 and go to RD_LO.
  - DONE: done=1 (registered, stays high). If init=1, clear done the next cycle, set idx<=0 and go to RD_LO (restart).
- dec_req drops the cycle after ack is sampled; it never stays high in WR_LO.
- mem_wr_en is high only in WR_LO and WR_HI; exactly 2*NUM_WORDS writes per batch.
- init is ignored in RD_LO..WR_HI; no restart mid-batch.
- Latency with zero-wait ack: 5 clocks per word. done rises 5*NUM_WORDS+1 clocks after the edge that samples init (76 for defaults). Each cycle of ack delay adds 1 clock.
- idx width is clog2(NUM_WORDS). Address arithmetic is truncated to AW bits, so it wraps at 2^AW.

Optional Feature:
- Macro HSEQ_ERR_STATS_EN.
- When defined:
  - On each ack, if dec_result[15:14]==2'b01 then sgl_cnt++.
  - If dec_result[15:14]==2'b10 then dbl_cnt++.
  - Counters saturate at 255 and clear on reset and on each accepted init.
- When undefined: sgl_cnt and dbl_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Defaults, decoder acks in the same cycle, 15 clean words preloaded at 64..93 -> mem 94..123 holds the decoder outputs byte-for-byte; done rises exactly 76 clocks after init; 30 write strobes observed.
- Decoder delays ack by 3 cycles on word 7 only -> dec_word stable throughout; done at 79 clocks; no extra writes.
- Assert reset during WR_LO of word 4 -> all outputs 0 immediately; mem 102..123 untouched; a new init then runs a full batch correctly.
- init pulses during RD_HI and DEC -> ignored; after done, init -> done=0 next cycle and the second batch repeats identical results.
- With HSEQ_ERR_STATS_EN, decoder returns flags 01 on 4 words and 10 on 2 words -> sgl_cnt=4, dbl_cnt=2 at done. Without the macro, both read 0.
- NUM_WORDS=1, SRC_BASE=254 -> reads 254 and 255; done at 6 clocks.

Source files
------------

// File: rtl/hamming_seq_ctrl_if.sv
// Bus between the SECDED decode sequencer and its memory/decoder environment.
interface hamming_seq_ctrl_if #(
  parameter int AW = 8
);
  logic          init;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data;
  logic          dec_req;
  logic [15:0]   dec_word;
  logic          dec_ack;
  logic [15:0]   dec_result;
  logic [7:0]    sgl_cnt;
  logic [7:0]    dbl_cnt;

  modport master (
    input  init, mem_rd_data, dec_ack, dec_result,
    output done, mem_addr, mem_wr_en, mem_wr_data, dec_req, dec_word, sgl_cnt, dbl_cnt
  );

  modport slave (
    output init, mem_rd_data, dec_ack, dec_result,
    input  done, mem_addr, mem_wr_en, mem_wr_data, dec_req, dec_word, sgl_cnt, dbl_cnt
  );
endinterface

// File: rtl/hamming_seq_ctrl.sv
// Walks NUM_WORDS encoded words through the external SECDED decoder and writes results back.
// Optional error statistics counters: define HSEQ_ERR_STATS_EN.
module hamming_seq_ctrl #(
  parameter int AW        = 8,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 94,
  parameter int NUM_WORDS = 15
) (
  input  logic               clk,
  input  logic               reset,
  hamming_seq_ctrl_if.master bus
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, DEC, WR_LO, WR_HI, DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [15:0]   r_res;
  logic          r_done;

  logic          w_start;
  logic          w_last;
  logic          w_accept;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_dst;

  assign w_start  = bus.init && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = (r_state == DEC) && bus.dec_ack;
  // Byte offset of the current word; sums truncate to AW bits so addresses wrap.
  assign w_off    = AW'({r_idx, 1'b0});
  assign w_src    = AW'(SRC_BASE) + w_off;
  assign w_dst    = AW'(DST_BASE) + w_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_idx  <= '0;
        r_done <= 1'b0;
      end else if (r_state == DONE) begin
        r_done <= 1'b1;
      end
      if (r_state == RD_LO) r_lo <= bus.mem_rd_data;
      if (r_state == RD_HI) r_hi <= bus.mem_rd_data;
      if (w_accept)         r_res <= bus.dec_result;
      if ((r_state == WR_HI) && !w_last) r_idx <= r_idx + IW'(1);
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    bus.dec_req     = 1'b0;
    bus.dec_word    = '0;
    case (r_state)
      IDLE:  if (bus.init) w_next = RD_LO;
      RD_LO: begin
        bus.mem_addr = w_src;
        w_next       = RD_HI;
      end
      RD_HI: begin
        bus.mem_addr = w_src + AW'(1);
        w_next       = DEC;
      end
      DEC: begin
        bus.dec_req  = 1'b1;
        bus.dec_word = {r_hi, r_lo};
        if (bus.dec_ack) w_next = WR_LO;
      end
      WR_LO: begin
        bus.mem_addr    = w_dst;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = r_res[7:0];
        w_next          = WR_HI;
      end
      WR_HI: begin
        bus.mem_addr    = w_dst + AW'(1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = r_res[15:8];
        w_next          = w_last ? DONE : RD_LO;
      end
      DONE:    if (bus.init) w_next = RD_LO;
      default: w_next = IDLE;
    endcase
  end

  assign bus.done = r_done;

`ifdef HSEQ_ERR_STATS_EN
  logic [7:0] r_sgl;
  logic [7:0] r_dbl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sgl <= '0;
      r_dbl <= '0;
    end else if (w_start) begin
      r_sgl <= '0;
      r_dbl <= '0;
    end else if (w_accept) begin
      if ((bus.dec_result[15:14] == 2'b01) && (r_sgl != '1)) r_sgl <= r_sgl + 8'd1;
      if ((bus.dec_result[15:14] == 2'b10) && (r_dbl != '1)) r_dbl <= r_dbl + 8'd1;
    end
  end

  assign bus.sgl_cnt = r_sgl;
  assign bus.dbl_cnt = r_dbl;
`else
  assign bus.sgl_cnt = '0;
  assign bus.dbl_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Randomized bench for hamming_seq_ctrl with memory, decoder and result model kept here.
module tb_hamming_seq_ctrl;

  localparam int NW  = 15;
  localparam int SRC = 64;
  localparam int DST = 94;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hamming_seq_ctrl_if #(.AW(8)) bus ();
  hamming_seq_ctrl_if #(.AW(8)) bus2 ();

  hamming_seq_ctrl #(.AW(8), .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  hamming_seq_ctrl #(.AW(8), .SRC_BASE(254), .DST_BASE(DST), .NUM_WORDS(1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.master)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem  [0:255];
  logic [7:0]  mem2 [0:255];
  logic [1:0]  flags_tab [0:15];
  logic [15:0] src_words [0:NW-1];
  int req_cycles = 0, acks = 0, unstable = 0, overlap = 0, writes = 0, writes2 = 0;
  int delay_word = -1, delay_amt = 0;
  logic [15:0] prev_word;
  logic [15:0] cap_q[$];
  int rd_q2[$];

  // Memory and decoder behaviour of the environment
  assign bus.mem_rd_data  = mem[bus.mem_addr];
  assign bus.dec_ack      = bus.dec_req && (req_cycles > ((acks == delay_word) ? delay_amt : 0));
  assign bus.dec_result   = {flags_tab[acks[3:0]], 3'b000, bus.dec_word[10:0] ^ 11'h2A5};
  assign bus2.mem_rd_data = mem2[bus2.mem_addr];
  assign bus2.dec_ack     = bus2.dec_req;
  assign bus2.dec_result  = {2'b00, 3'b000, bus2.dec_word[10:0] ^ 11'h2A5};

  always @(posedge clk) begin
    if (bus.mem_wr_en)  begin mem[bus.mem_addr]   = bus.mem_wr_data;  writes++;  end
    if (bus2.mem_wr_en) begin mem2[bus2.mem_addr] = bus2.mem_wr_data; writes2++; end
  end

  always @(negedge clk) begin
    if (bus.dec_req && bus.mem_wr_en) overlap++;
    if (bus.dec_req) begin
      if (req_cycles == 0) cap_q.push_back(bus.dec_word);
      else if (bus.dec_word !== prev_word) unstable++;
      prev_word = bus.dec_word;
      req_cycles++;
    end else if (req_cycles > 0) begin
      acks++;
      req_cycles = 0;
    end
    if (!bus2.mem_wr_en && bus2.mem_addr != 8'd0) rd_q2.push_back(int'(bus2.mem_addr));
  end

  function automatic logic [15:0] exp_res(input int k);
    return {flags_tab[k], 3'b000, src_words[k][10:0] ^ 11'h2A5};
  endfunction

  function automatic int count_flag(input logic [1:0] f);
    int n = 0;
    for (int k = 0; k < NW; k++) if (flags_tab[k] == f) n++;
    return n;
  endfunction

  task automatic load_batch(input bit stats_mix);
    for (int k = 0; k < NW; k++) begin
      src_words[k] = 16'($urandom);
      mem[SRC + 2*k]     = src_words[k][7:0];
      mem[SRC + 2*k + 1] = src_words[k][15:8];
      if (stats_mix) flags_tab[k] = (k < 4) ? 2'b01 : (k < 6) ? 2'b10 : ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00);
      else           flags_tab[k] = 2'($urandom);
    end
    flags_tab[15] = 2'b00;
    if (stats_mix) begin
      for (int k = NW - 1; k > 0; k--) begin
        int j = $urandom_range(0, k);
        logic [1:0] t = flags_tab[k];
        flags_tab[k] = flags_tab[j];
        flags_tab[j] = t;
      end
    end
    for (int a = DST; a < DST + 2*NW; a++) mem[a] = 8'hEE;
  endtask

  task automatic run_batch(input bit glitch, output int cycles, output logic first_done);
    bit g1 = 0, g2 = 0;
    acks = 0; writes = 0; unstable = 0; overlap = 0; req_cycles = 0; cap_q.delete();
    @(negedge clk); bus.init = 1'b1;
    @(negedge clk); bus.init = 1'b0;
    first_done = bus.done;
    cycles = 0;
    while (!bus.done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      bus.init = 1'b0;
      if (glitch && !g1 && !bus.mem_wr_en && bus.mem_addr == 8'(SRC + 5)) begin
        bus.init = 1'b1; g1 = 1;
      end else if (glitch && !g2 && bus.dec_req && acks == 5) begin
        bus.init = 1'b1; g2 = 1;
      end
    end
    bus.init = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.init = 1'b0; bus2.init = 1'b0;
    #1;
    total++; if (bus.done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.mem_wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.mem_wr_en); end
    total++; if (bus.mem_addr !== 8'd0)    begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 8'd0) begin bad++; $display("FAIL reset_wr_data got=%0h exp=0", bus.mem_wr_data); end
    total++; if (bus.dec_req !== 1'b0)     begin bad++; $display("FAIL reset_dec_req got=%b exp=0", bus.dec_req); end
    total++; if (bus.dec_word !== 16'd0)   begin bad++; $display("FAIL reset_dec_word got=%0h exp=0", bus.dec_word); end
    total++; if (bus.sgl_cnt !== 8'd0 || bus.dbl_cnt !== 8'd0)
      begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.sgl_cnt, bus.dbl_cnt); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.mem_wr_en !== 1'b0)
      begin bad++; $display("FAIL idle_after_reset done=%b wr=%b exp=0/0", bus.done, bus.mem_wr_en); end
  endtask

  task automatic check_results(input string tag, input int cycles, input int exp_cycles);
    int es, ed;
    total++; if (cycles != exp_cycles) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", tag, cycles, exp_cycles); end
    total++; if (writes != 2*NW)       begin bad++; $display("FAIL %s_writes got=%0d exp=%0d", tag, writes, 2*NW); end
    total++; if (unstable != 0)        begin bad++; $display("FAIL %s_word_stable got=%0d exp=0", tag, unstable); end
    total++; if (overlap != 0)         begin bad++; $display("FAIL %s_req_in_write got=%0d exp=0", tag, overlap); end
    total++; if (cap_q.size() != NW)   begin bad++; $display("FAIL %s_requests got=%0d exp=%0d", tag, cap_q.size(), NW); end
    for (int k = 0; k < NW; k++) begin
      logic [15:0] got = {mem[DST + 2*k + 1], mem[DST + 2*k]};
      total++; if (got !== exp_res(k)) begin bad++; $display("FAIL %s_result[%0d] got=%h exp=%h", tag, k, got, exp_res(k)); end
      if (k < cap_q.size()) begin
        total++; if (cap_q[k] !== src_words[k]) begin bad++; $display("FAIL %s_dec_word[%0d] got=%h exp=%h", tag, k, cap_q[k], src_words[k]); end
      end
    end
`ifdef HSEQ_ERR_STATS_EN
    es = count_flag(2'b01); ed = count_flag(2'b10);
`else
    es = 0; ed = 0;
`endif
    total++; if (bus.sgl_cnt !== 8'(es) || bus.dbl_cnt !== 8'(ed))
      begin bad++; $display("FAIL %s_stats got=%0d/%0d exp=%0d/%0d", tag, bus.sgl_cnt, bus.dbl_cnt, es, ed); end
  endtask

  task automatic test_basic();
    int cyc; logic fd;
    delay_word = -1; delay_amt = 0;
    load_batch(0);
    run_batch(0, cyc, fd);
    check_results("basic", cyc, 5*NW + 1);
  endtask

  task automatic test_ack_delay();
    int cyc; logic fd;
    delay_word = 7; delay_amt = 3;
    load_batch(0);
    run_batch(0, cyc, fd);
    check_results("ack_delay", cyc, 5*NW + 4);
    delay_word = -1; delay_amt = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0, cyc; logic fd; bit untouched = 1;
    load_batch(0);
    acks = 0; writes = 0; req_cycles = 0; cap_q.delete();
    @(negedge clk); bus.init = 1'b1;
    @(negedge clk); bus.init = 1'b0;
    while (!(bus.mem_wr_en && bus.mem_addr == 8'(DST + 8)) && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) begin bad++; $display("FAIL mid_reach_word4 got=timeout exp=WR_LO"); end
    reset = 1'b1;
    #1;
    total++; if ({bus.done, bus.mem_wr_en, bus.dec_req} !== 3'b000 || bus.mem_addr !== 8'd0 || bus.mem_wr_data !== 8'd0)
      begin bad++; $display("FAIL mid_reset_outputs got=%b%b%b addr=%0d exp=000 addr=0", bus.done, bus.mem_wr_en, bus.dec_req, bus.mem_addr); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int a = DST + 8; a < DST + 2*NW; a++) if (mem[a] !== 8'hEE) untouched = 0;
    total++; if (!untouched) begin bad++; $display("FAIL mid_untouched got=written exp=untouched"); end
    total++; if (writes != 8) begin bad++; $display("FAIL mid_writes got=%0d exp=8", writes); end
    for (int k = 0; k < 4; k++) begin
      total++; if ({mem[DST + 2*k + 1], mem[DST + 2*k]} !== exp_res(k))
        begin bad++; $display("FAIL mid_partial[%0d] got=%h exp=%h", k, {mem[DST + 2*k + 1], mem[DST + 2*k]}, exp_res(k)); end
    end
    for (int a = DST; a < DST + 2*NW; a++) mem[a] = 8'hEE;
    run_batch(0, cyc, fd);
    check_results("after_reset", cyc, 5*NW + 1);
  endtask

  task automatic test_init_ignored();
    int cyc; logic fd;
    logic [7:0] first [0:2*NW-1];
    load_batch(0);
    run_batch(1, cyc, fd);
    check_results("glitch", cyc, 5*NW + 1);
    for (int a = 0; a < 2*NW; a++) begin first[a] = mem[DST + a]; mem[DST + a] = 8'h00; end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done_level got=%b exp=1", bus.done); end
    run_batch(0, cyc, fd);
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL restart_done_clear got=%b exp=0", fd); end
    check_results("restart", cyc, 5*NW + 1);
    for (int a = 0; a < 2*NW; a++) begin
      total++; if (mem[DST + a] !== first[a]) begin bad++; $display("FAIL repeat[%0d] got=%h exp=%h", a, mem[DST + a], first[a]); end
    end
  endtask

  task automatic test_stats();
    int cyc; logic fd;
    load_batch(1);
    run_batch(0, cyc, fd);
    check_results("stats", cyc, 5*NW + 1);
  endtask

  task automatic test_single_word();
    int cyc = 0;
    logic [15:0] w = 16'($urandom);
    logic [15:0] exp = {5'b00000, w[10:0] ^ 11'h2A5};
    mem2[254] = w[7:0]; mem2[255] = w[15:8]; mem2[DST] = 8'h00; mem2[DST + 1] = 8'h00;
    writes2 = 0; rd_q2.delete();
    @(negedge clk); bus2.init = 1'b1;
    @(negedge clk); bus2.init = 1'b0;
    while (!bus2.done && cyc < 100) begin @(negedge clk); cyc++; end
    total++; if (cyc != 6) begin bad++; $display("FAIL single_latency got=%0d exp=6", cyc); end
    total++; if (rd_q2.size() != 2 || rd_q2[0] != 254 || rd_q2[1] != 255)
      begin bad++; $display("FAIL single_read_addrs got_n=%0d exp=254,255", rd_q2.size()); end
    total++; if ({mem2[DST + 1], mem2[DST]} !== exp) begin bad++; $display("FAIL single_result got=%h exp=%h", {mem2[DST + 1], mem2[DST]}, exp); end
    total++; if (writes2 != 2) begin bad++; $display("FAIL single_writes got=%0d exp=2", writes2); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) flags_tab[i] = 2'b00;
    for (int a = 0; a < 256; a++) begin mem[a] = 8'h00; mem2[a] = 8'h00; end
    test_reset();
    test_basic();
    test_ack_delay();
    test_reset_mid();
    test_init_ignored();
    test_stats();
    test_single_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
